serial_twos_unit: RTL
=====================

Name: serial_twos_unit

Overview:
Parametrised successor to the single-bit serial two's-complement inverter. Accepts WIDTH-bit words LSB first, one bit per valid beat. Per word it applies one of three modes: pass, negate or absolute value. Absolute value needs the sign, which arrives last, so every word is buffered in full. The block then re-emits the result serially, LSB first, and also presents it as a parallel word with an overflow flag. It sits between serial bit-stream producers and consumers in the arithmetic datapath.

Parameters:
WIDTH, 8, bits per word; legal range 2..32.

Ports:
t_clk  input  1  clock, all state updates on the rising edge
r_n  input  1  asynchronous active-low reset
in_valid  input  1  in_bit is a real bit this cycle
in_start  input  1  qualified by in_valid: this beat is bit 0 (LSB) of a new word
in_bit  input  1  serial data, LSB first
mode  input  2  00 pass, 01 negate, 10 absolute value, 11 reserved (treated as pass); sampled only on a start beat
out_valid  output  1  out_bit is valid
out_start  output  1  high with out_bit 0 of each result word
out_bit  output  1  serial result, LSB first
out_word  output  WIDTH  parallel result of the last completed word
word_done  output  1  one-cycle pulse; out_word and ovf updated this cycle
ovf  output  1  last word was negated while equal to the most-negative value

Behaviour:
- Reset (r_n=0, takes effect immediately, asynchronously): bit counter=0, state IDLE, mode register=00, input buffer=0. Output shift register=0, emit counter=0. out_valid, out_start, out_bit, word_done and ovf all go to 0. out_word=0.
- Input FSM, state IDLE:
  - in_valid & in_start: latch mode, shift in_bit into the buffer, counter=1, go to COLLECT.
  - Any other valid beat without in_start: ignored; stay in IDLE.
- Input FSM, state COLLECT:
  - in_valid=0: counter and buffer hold. Gaps of any length are allowed.
  - in_valid & in_start: abort. Discard the partial word, restart at bit 0, re-latch mode. No output is produced for the discarded word.
  - in_valid & ~in_start & counter<WIDTH-1: shift in_bit in, counter+1.
  - in_valid & ~in_start & counter==WIDTH-1: this is the last bit, i.e. the sign bit. The word is complete. Go to IDLE, counter=0.
- Completion, on the same edge:
  - Form word W = buffer with the current in_bit as MSB.
  - inv = (mode==01) | (mode==10 & W[WIDTH-1]).
  - out_word = inv ? (~W+1) mod 2^WIDTH : W.
  - ovf = inv & (W == 1 followed by WIDTH-1 zeros). The result then equals W.
  - word_done=1 for exactly one cycle.
  - Output serializer loads W and inv, clears its seen_one flag, and sets emit counter=0.
- Emission:
  - Runs for WIDTH consecutive cycles starting on the completion edge, independent of in_valid.
  - out_valid=1 throughout; out_start=1 in the first cycle only.
  - out_bit = b XOR (inv & seen_one), where b is the current buffered bit. seen_one sets after a 1 is emitted from the original word.
  - After WIDTH cycles, out_valid=0 and out_bit=0.
- Latency: from the start beat with no gaps, out bit 0 appears WIDTH cycles later. Serial out_bit always matches out_word.
- Back-to-back words: the earliest next completion lands on the edge right after the final emitted bit. The serializer reloads on that edge, so out_valid stays high with no bubble.
- Input beats are not back-pressured; the architecture guarantees no overrun.
- Reset asserted mid-word or mid-emission: everything clears as above. No partial output follows reset release.

Test Plan:
1. WIDTH=8, mode=01, word 0x06 (bits 0,1,1,0,0,0,0,0) -> out_word=0xFA, serial 0,1,0,1,1,1,1,1, ovf=0, one word_done pulse, out_start with bit 0.
2. mode=10, word 0xF3 -> out_word=0x0D, serial 1,0,1,1,0,0,0,0. Then mode=10, word 0x05 -> out_word=0x05, unchanged serial stream.
3. mode=01, word 0x80 -> out_word=0x80, ovf=1. Then mode=01, word 0x00 -> 0x00, ovf=0. Mode=11, word 0xA5 -> 0xA5.
4. Two words back-to-back with no gaps (0x01 negate, 0x7F pass) -> 16 continuous out_valid cycles, outputs 0xFF then 0x7F, out_start twice, 8 cycles apart.
5. in_valid gaps of 3 cycles inside a word -> same result as the gap-free case. in_start after 5 bits -> partial word discarded, only the restarted word is emitted.
6. Drive r_n low for one cycle in the 4th cycle of emission -> out_valid drops immediately, all outputs 0. A new word after release produces the correct result.

Source files
------------

// File: rtl/serial_twos_unit.sv
// serial_twos_unit: collects WIDTH-bit words LSB first and applies pass, negate
// or absolute value to each one. The result is re-emitted serially (LSB first)
// and is also presented as a parallel word with an overflow flag.
//
// Ports:
//   t_clk      clock, rising edge
//   r_n        asynchronous active-low reset
//   in_valid   in_bit carries a real bit this cycle
//   in_start   with in_valid: this beat is bit 0 of a new word
//   in_bit     serial input data, LSB first
//   mode       00 pass, 01 negate, 10 absolute value, 11 pass (sampled on start)
//   out_valid  out_bit is valid
//   out_start  marks bit 0 of each emitted result
//   out_bit    serial result, LSB first
//   out_word   parallel result of the last completed word
//   word_done  one-cycle pulse when out_word/ovf update
//   ovf        last word was negated while equal to the most-negative value
module serial_twos_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r_n,
    input  logic             in_valid,
    input  logic             in_start,
    input  logic             in_bit,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic             out_start,
    output logic             out_bit,
    output logic [WIDTH-1:0] out_word,
    output logic             word_done,
    output logic             ovf
);

    localparam int unsigned     CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [1:0]        r_mode, w_mode_nxt;
    logic [WIDTH-1:0]  r_buf, w_buf_nxt;
    logic              w_done;
    logic [WIDTH-1:0]  w_word;
    logic              w_inv;

    logic [WIDTH-1:0]  r_osr;
    logic              r_inv;
    logic              r_seen;
    logic [CW-1:0]     r_ecnt;

    // Input FSM state register
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Input FSM next state and collection datapath.
    // Bits enter at the top of r_buf, so after WIDTH-1 beats bit 0 sits in
    // r_buf[1] and the full word is the live sign bit above r_buf[WIDTH-1:1].
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_buf_nxt   = r_buf;
        w_done      = 1'b0;
        w_word      = {in_bit, r_buf[WIDTH-1:1]};
        w_inv       = (r_mode == 2'b01) | ((r_mode == 2'b10) & in_bit);

        case (r_state)
            S_IDLE: begin
                if (in_valid && in_start) begin
                    w_mode_nxt  = mode;
                    w_buf_nxt   = {in_bit, {(WIDTH-1){1'b0}}};
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (in_valid) begin
                    if (in_start) begin
                        // restart discards the partial word
                        w_mode_nxt = mode;
                        w_buf_nxt  = {in_bit, {(WIDTH-1){1'b0}}};
                        w_cnt_nxt  = CW'(1);
                    end else if (r_cnt == LAST) begin
                        w_done      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_buf_nxt = {in_bit, r_buf[WIDTH-1:1]};
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Collection registers
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            r_cnt  <= '0;
            r_mode <= 2'b00;
            r_buf  <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_mode <= w_mode_nxt;
            r_buf  <= w_buf_nxt;
        end
    end

    // Parallel result and serial emitter. Serial negation inverts every bit
    // after the first 1 of the original word; a new completion reloads the
    // emitter on the same edge the previous word finishes, so no bubble.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            r_osr     <= '0;
            r_inv     <= 1'b0;
            r_seen    <= 1'b0;
            r_ecnt    <= '0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_bit   <= 1'b0;
            out_word  <= '0;
            word_done <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            word_done <= w_done;
            out_start <= w_done;
            if (w_done) begin
                out_word  <= w_inv ? (~w_word + WIDTH'(1)) : w_word;
                ovf       <= w_inv & (w_word == MOST_NEG);
                r_osr     <= w_word >> 1;
                r_inv     <= w_inv;
                r_seen    <= w_word[0];
                r_ecnt    <= '0;
                out_valid <= 1'b1;
                out_bit   <= w_word[0];
            end else if (out_valid) begin
                if (r_ecnt == LAST) begin
                    out_valid <= 1'b0;
                    out_bit   <= 1'b0;
                end else begin
                    out_bit <= r_osr[0] ^ (r_inv & r_seen);
                    r_seen  <= r_seen | r_osr[0];
                    r_osr   <= r_osr >> 1;
                    r_ecnt  <= r_ecnt + CW'(1);
                end
            end
        end
    end

endmodule
